// File: rtl/avst_tx_pkt_buffer.sv
// avst_tx_pkt_buffer: store-and-forward AVST packet FIFO placed ahead of the
// Ethernet MAC TX port. A packet becomes visible on the output only once its
// end beat has been written, so the MAC never sees a bubble inside a packet.
// Packets that cannot fit in the buffer are dropped whole.
// Optional build macro: AVST_TX_PKT_BUF_ERR_DROP_EN -- when defined, packets
// whose end beat carries a non-zero error are discarded instead of forwarded.
module avst_tx_pkt_buffer #(
    parameter int DWIDTH    = 512,
    parameter int ERR_WIDTH = 1,
    parameter int DEPTH     = 512,
    localparam int EMPTY_W  = $clog2(DWIDTH/8),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic                 in_end,
    input  logic [DWIDTH-1:0]    in_data,
    input  logic [EMPTY_W-1:0]   in_empty,
    input  logic [ERR_WIDTH-1:0] in_error,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic                 out_start,
    output logic                 out_end,
    output logic [DWIDTH-1:0]    out_data,
    output logic [EMPTY_W-1:0]   out_empty,
    output logic [ERR_WIDTH-1:0] out_error,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     pkt_count,
    output logic                 ovf_drop
);
    localparam int ADDR_W  = CNT_W - 1;
    localparam int ENTRY_W = 2 + EMPTY_W + ERR_WIDTH + DWIDTH;

    typedef enum logic [1:0] {IDLE, PKT, DROP} wr_state_t;

    wr_state_t          state_reg, state_next;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_entry_reg;
    logic [CNT_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   pkt_start_reg, pkt_start_next;
    logic [CNT_W-1:0]   commit_ptr_reg, commit_ptr_next;
    logic [CNT_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   pkt_count_reg;
    logic               out_valid_reg;
    logic               ovf_drop_reg;
    logic               full, accept, wr_en, commit, drop_now;
    logic               has_committed, rd_load, out_end_fire, err_drop;

`ifdef AVST_TX_PKT_BUF_ERR_DROP_EN
    assign err_drop = |in_error;
`else
    assign err_drop = 1'b0;
`endif

    // Full when the RAM addresses meet but the wrap bits differ.
    assign full   = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                    (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
    assign in_ready = (state_reg == DROP) ? 1'b1 : !full;
    assign accept   = in_valid && in_ready;

    // Write state machine: next state, write enable and pointer updates.
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        pkt_start_next  = pkt_start_reg;
        commit_ptr_next = commit_ptr_reg;
        wr_en           = 1'b0;
        commit          = 1'b0;
        drop_now        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && in_start) begin
                    wr_en          = 1'b1;
                    pkt_start_next = wr_ptr_reg;
                    wr_ptr_next    = wr_ptr_reg + 1'b1;
                    if (in_end) begin
                        if (err_drop) begin
                            wr_ptr_next = wr_ptr_reg;
                        end else begin
                            commit          = 1'b1;
                            commit_ptr_next = wr_ptr_reg + 1'b1;
                        end
                    end else begin
                        state_next = PKT;
                    end
                end
            end
            PKT: begin
                // Full with nothing committed ahead: this packet can never fit.
                if (full && (pkt_count_reg == '0)) begin
                    wr_ptr_next = pkt_start_reg;
                    drop_now    = 1'b1;
                    state_next  = DROP;
                end else if (accept) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (in_end) begin
                        state_next = IDLE;
                        if (err_drop) begin
                            wr_ptr_next = pkt_start_reg;
                        end else begin
                            commit          = 1'b1;
                            commit_ptr_next = wr_ptr_reg + 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && in_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write-side state and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            pkt_start_reg  <= '0;
            commit_ptr_reg <= '0;
            ovf_drop_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            pkt_start_reg  <= pkt_start_next;
            commit_ptr_reg <= commit_ptr_next;
            ovf_drop_reg   <= drop_now;
        end
    end

    // Packet storage RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= {in_start, in_end, in_empty, in_error, in_data};
        end
    end

    // Reads never pass the commit point, so they never collide with writes.
    assign has_committed = (rd_ptr_reg != commit_ptr_reg);
    assign rd_load       = has_committed && (!out_valid_reg || out_ready);
    assign out_end_fire  = out_valid_reg && out_ready && out_end;

    // Registered RAM read feeding the show-ahead output stage.
    always_ff @(posedge clk) begin
        if (rd_load) begin
            rd_entry_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    // Output-stage valid, read pointer and stored-packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            pkt_count_reg <= '0;
        end else begin
            if (rd_load) begin
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (commit && !out_end_fire) begin
                pkt_count_reg <= pkt_count_reg + 1'b1;
            end else if (!commit && out_end_fire) begin
                pkt_count_reg <= pkt_count_reg - 1'b1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_start = out_valid_reg & rd_entry_reg[ENTRY_W-1];
    assign out_end   = out_valid_reg & rd_entry_reg[ENTRY_W-2];
    assign out_empty = rd_entry_reg[DWIDTH+ERR_WIDTH +: EMPTY_W];
    assign out_data  = rd_entry_reg[DWIDTH-1:0];
`ifdef AVST_TX_PKT_BUF_ERR_DROP_EN
    assign out_error = '0;
`else
    assign out_error = rd_entry_reg[DWIDTH +: ERR_WIDTH];
`endif
    assign pkt_count = pkt_count_reg;
    assign ovf_drop  = ovf_drop_reg;

endmodule

// File: tb/tb_avst_tx_pkt_buffer.sv
// Testbench for avst_tx_pkt_buffer (DWIDTH=64, DEPTH=8). A packet-level model
// predicts the output beat stream and pkt_count; a per-cycle compare process
// checks the DUT against it, and directed checks pin latency, flow control,
// overflow dropping, error handling and mid-packet reset.
module tb_avst_tx_pkt_buffer;
    localparam int DW   = 64;
    localparam int EW   = 3;
    localparam int ERRW = 1;
    localparam int DEP  = 8;
    localparam int CW   = 4;
`ifdef AVST_TX_PKT_BUF_ERR_DROP_EN
    localparam bit ERR_DROP = 1'b1;
`else
    localparam bit ERR_DROP = 1'b0;
`endif

    typedef logic [2+EW+ERRW+DW-1:0] beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_start, in_end;
    logic [DW-1:0]   in_data;
    logic [EW-1:0]   in_empty;
    logic [ERRW-1:0] in_error;
    logic            in_ready;
    logic            out_valid, out_start, out_end;
    logic [DW-1:0]   out_data;
    logic [EW-1:0]   out_empty;
    logic [ERRW-1:0] out_error;
    logic            out_ready;
    logic [CW-1:0]   pkt_count;
    logic            ovf_drop;

    int tests = 0;
    int fails = 0;

    // Model state
    beat_t exp_q[$];
    beat_t cur_q[$];
    int    m_pkt_count = 0;
    bit    m_in_pkt = 1'b0;
    bit    out_mid = 1'b0;
    int    m_ovf = 0;
    int    m_err_drops = 0;
    int    ovf_seen = 0;
    int    rx_pkts = 0;
    int    rx_beats = 0;
    int    stalls = 0;
    logic [EW-1:0]   last_end_empty = '0;
    logic [ERRW-1:0] last_end_error = '0;
    beat_t act_beat;

    avst_tx_pkt_buffer #(.DWIDTH(DW), .ERR_WIDTH(ERRW), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
        .in_data(in_data), .in_empty(in_empty), .in_error(in_error),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_start(out_start), .out_end(out_end),
        .out_data(out_data), .out_empty(out_empty), .out_error(out_error),
        .out_ready(out_ready),
        .pkt_count(pkt_count), .ovf_drop(ovf_drop)
    );

    always #5 clk = ~clk;

    // Per-cycle compare against the packet model, then advance the model with
    // the handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (int'(pkt_count) != m_pkt_count) begin
                fails++;
                $display("FAIL pkt_count: got %0d, required %0d", pkt_count, m_pkt_count);
            end
            if (out_mid) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL out_bubble: out_valid=%b inside a packet, required 1", out_valid);
                end
            end
            if (out_valid) begin
                act_beat = {out_start, out_end, out_empty, out_error, out_data};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_beat: got unexpected beat %h, required no beat", act_beat);
                end else if (act_beat !== exp_q[0]) begin
                    fails++;
                    $display("FAIL out_beat: got %h, required %h", act_beat, exp_q[0]);
                end
            end
            if (ovf_drop) ovf_seen++;

            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) exp_q.delete(0);
                rx_beats++;
                out_mid = !out_end;
                if (out_end) begin
                    m_pkt_count--;
                    rx_pkts++;
                    last_end_empty = out_empty;
                    last_end_error = out_error;
                end
            end
            if (in_valid && in_ready) begin
                if (!m_in_pkt && in_start) begin
                    cur_q.delete();
                    m_in_pkt = 1'b1;
                end
                if (m_in_pkt) begin
                    cur_q.push_back({in_start, in_end, in_empty,
                                     ERR_DROP ? {ERRW{1'b0}} : in_error, in_data});
                    if (in_end) begin
                        m_in_pkt = 1'b0;
                        if (cur_q.size() > DEP) begin
                            m_ovf++;
                        end else if (ERR_DROP && (in_error != '0)) begin
                            m_err_drops++;
                        end else begin
                            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                            m_pkt_count++;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Hold the current beat until the DUT accepts it (bounded).
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
    endtask

    // Send the first nb beats of a len-beat packet.
    task automatic send_pkt(input int len, input int nb, input logic [EW-1:0] emp,
                            input logic err, input logic [7:0] tag);
        for (int b = 0; b < nb; b++) begin
            in_valid = 1'b1;
            in_start = (b == 0);
            in_end   = (b == len - 1);
            in_empty = (b == len - 1) ? emp : '0;
            in_error = (b == len - 1) ? err : 1'b0;
            in_data  = {tag, 56'(b)};
            wait_accept();
        end
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
        in_empty = '0;   in_error = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rp, rb, cont;
        rst_n = 1'b0;
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
        in_data = '0; in_empty = '0; in_error = '0;
        out_ready = 1'b1;
        cycles(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_start", out_start, 0);
        check("rst_out_end", out_end, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_ovf_drop", ovf_drop, 0);
        rst_n = 1'b1;
        cycles(1);
        check("rel_in_ready", in_ready, 1);

        // Single 4-beat packet: latency and framing
        send_pkt(4, 4, 3'd5, 1'b0, 8'h11);
        check("lat_n1_out_valid", out_valid, 0);
        check("t1_pkt_count_1", pkt_count, 1);
        cycles(1);
        check("lat_n2_out_valid", out_valid, 1);
        check("lat_n2_out_start", out_start, 1);
        cycles(4);
        check("t1_pkt_count_0", pkt_count, 0);
        check("t1_rx_beats", rx_beats, 4);
        check("t1_rx_pkts", rx_pkts, 1);
        check("t1_end_empty", last_end_empty, 5);

        // Oversize packet dropped, next packet intact
        send_pkt(10, 10, 3'd0, 1'b0, 8'h22);
        cycles(5);
        check("t2_ovf_seen", ovf_seen, 1);
        check("t2_model_ovf", m_ovf, 1);
        check("t2_pkt_count", pkt_count, 0);
        check("t2_rx_pkts_nodrop", rx_pkts, 1);
        send_pkt(2, 2, 3'd1, 1'b0, 8'h23);
        cycles(6);
        check("t2_rx_pkts", rx_pkts, 2);
        check("t2_rx_beats", rx_beats, 6);

        // Two packets stored with out_ready low, then drained back-to-back
        out_ready = 1'b0;
        stalls = 0;
        send_pkt(3, 3, 3'd2, 1'b0, 8'h31);
        send_pkt(3, 3, 3'd3, 1'b0, 8'h32);
        check("t3_no_stall", stalls, 0);
        check("t3_pkt_count", pkt_count, 2);
        out_ready = 1'b1;
        cont = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) cont++;
            cycles(1);
        end
        check("t3_contiguous", cont, 6);
        check("t3_idle_after", out_valid, 0);
        check("t3_rx_pkts", rx_pkts, 4);

        // Fill with complete packets, then offer one more beat
        out_ready = 1'b0;
        send_pkt(3, 3, 3'd1, 1'b0, 8'h41);
        send_pkt(3, 3, 3'd2, 1'b0, 8'h42);
        send_pkt(3, 3, 3'd3, 1'b0, 8'h43);
        check("t4_pkt_count", pkt_count, 3);
        in_valid = 1'b1; in_start = 1'b1; in_end = 1'b1;
        in_empty = 3'd4; in_error = '0; in_data = {8'h44, 56'd0};
        for (int i = 0; i < 3; i++) begin
            check("t4_full_in_ready", in_ready, 0);
            cycles(1);
        end
        out_ready = 1'b1;
        check("t4_in_ready_at_accept", in_ready, 0);
        cycles(1);
        out_ready = 1'b0;
        check("t4_in_ready_after", in_ready, 1);
        cycles(1);
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_empty = '0;
        out_ready = 1'b1;
        cycles(20);
        check("t4_rx_pkts", rx_pkts, 8);
        check("t4_pkt_count", pkt_count, 0);

        // Errored packet
        rp = rx_pkts;
        send_pkt(3, 3, 3'd2, 1'b1, 8'h51);
        cycles(10);
        check("t5_rx_pkts", rx_pkts - rp, ERR_DROP ? 0 : 1);
        check("t5_err_drops", m_err_drops, ERR_DROP ? 1 : 0);
        check("t5_end_error", last_end_error, ERR_DROP ? 0 : 1);
        check("t5_pkt_count", pkt_count, 0);

        // Reset mid-packet with a stored packet on the output
        out_ready = 1'b0;
        send_pkt(2, 2, 3'd0, 1'b0, 8'h60);
        send_pkt(4, 2, 3'd0, 1'b0, 8'h61);
        cycles(1);
        check("t6_pre_out_valid", out_valid, 1);
        check("t6_pre_pkt_count", pkt_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_start", out_start, 0);
        check("t6_rst_pkt_count", pkt_count, 0);
        exp_q.delete(); cur_q.delete();
        m_in_pkt = 1'b0; m_pkt_count = 0; out_mid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);
        check("t6_rel_in_ready", in_ready, 1);
        out_ready = 1'b1;
        rp = rx_pkts; rb = rx_beats;
        send_pkt(2, 2, 3'd3, 1'b0, 8'h62);
        cycles(8);
        check("t6_rx_pkts", rx_pkts - rp, 1);
        check("t6_rx_beats", rx_beats - rb, 2);
        check("t6_pkt_count", pkt_count, 0);
        check("final_exp_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/avst_tx_pkt_buffer.md
Name: avst_tx_pkt_buffer

Overview:
- Store-and-forward packet FIFO that sits directly downstream of the AXIS-to-AVST converter, ahead of the Ethernet MAC TX AVST port.
- The MAC must not see a valid bubble once a packet has started. This block therefore releases a packet only after its end beat has been written.
- Packets that cannot fit are discarded whole. A packet is never truncated.

Parameters:
DWIDTH, 512, data bus width in bits.
ERR_WIDTH, 1, width of the error sideband.
DEPTH, 512, buffer depth in beats; power of two, at least 4.
EMPTY_W, $clog2(DWIDTH/8), width of the empty field (localparam).
CNT_W, $clog2(DEPTH)+1, width of the occupancy and packet counters (localparam).

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  AVST input beat valid.
in_start  in  1  first beat of packet.
in_end  in  1  last beat of packet.
in_data  in  DWIDTH  beat data.
in_empty  in  EMPTY_W  unused bytes on end beat.
in_error  in  ERR_WIDTH  error sideband, sampled on end beat.
in_ready  out  1  input may accept a beat.
out_valid  out  1  AVST output beat valid.
out_start  out  1  first beat of packet.
out_end  out  1  last beat of packet.
out_data  out  DWIDTH  beat data.
out_empty  out  EMPTY_W  unused bytes on end beat.
out_error  out  ERR_WIDTH  error sideband.
out_ready  in  1  downstream accept; ready latency 0.
pkt_count  out  CNT_W  number of complete packets stored.
ovf_drop  out  1  one-cycle pulse per packet dropped for overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - read pointer, write pointer, packet-start pointer, pkt_count and ovf_drop go to 0.
  - out_valid, out_start, out_end go to 0.
  - in_ready goes to 1 in the first cycle after reset release.
  - The write state machine goes to IDLE.
  - A reset mid-packet discards all stored data, including partial packets.
- Storage format: each entry holds {start, end, empty, error, data}. Write and read pointers are CNT_W bits wide, with a wrap bit. The buffer is full when the addresses are equal and the wrap bits differ.
- Input acceptance:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = !full, except in DROP state, where in_ready = 1.
- Write state machine:
  - IDLE: an accepted beat with in_start latches the packet-start pointer = write pointer and is written. The machine then goes to PKT, or stays in IDLE if in_end is also set.
  - PKT: accepted beats are written.
    - On in_end: commit the packet, pkt_count += 1, go to IDLE.
    - If the buffer becomes full before in_end while pkt_count == 0 (the packet is larger than DEPTH): rewind the write pointer to the packet-start pointer, pulse ovf_drop, go to DROP.
    - If full with pkt_count > 0: deassert in_ready and wait.
  - DROP: accept and discard beats until in_end, then go to IDLE.
  - An accepted beat in IDLE without in_start is discarded; no error is flagged.
- Read side:
  - A registered show-ahead output stage. The output stage loads from RAM when a committed beat exists and (!out_valid || out_ready).
  - Reading is gated by committed data only: the read may not pass the last committed end beat.
  - pkt_count decrements when a beat with out_end is accepted (out_valid && out_ready).
- Latency: an end beat accepted in cycle N with an empty buffer produces out_valid in cycle N+2. After that, output beats are back-to-back while out_ready = 1.
- Simultaneous packet commit and out_end acceptance in one cycle: pkt_count is unchanged.
- Simultaneous read and write of the same address is impossible by construction, because reads stay behind the commit point.
- out_valid may only deassert between packets. Within a packet it stays high until out_end is accepted, because the whole packet is already stored.

Optional Feature:
AVST_TX_PKT_BUF_ERR_DROP_EN
- Defined: a packet whose end beat carries a non-zero in_error is not committed. The write pointer rewinds to the packet-start pointer and pkt_count is unchanged. out_error is then always 0.
- Not defined: errored packets are forwarded unchanged, with in_error carried through to out_error on the end beat.

Test Plan:
- Single 4-beat packet (end-beat empty = 5), out_ready = 1: out_valid rises exactly 2 cycles after the in_end beat. The 4 output beats are contiguous, with start on beat 0, end on beat 3 and out_empty = 5. pkt_count goes 1 then 0.
- DEPTH = 8, a 10-beat packet: ovf_drop pulses once, out_valid never rises, pkt_count = 0. A following 2-beat packet is delivered intact.
- Two 3-beat packets with out_ready held at 0: in_ready stays 1 and pkt_count = 2. Releasing out_ready yields 6 contiguous beats.
- Fill the buffer with complete packets, then offer another beat: in_ready = 0 while full. It returns to 1 one cycle after the first output beat is accepted.
- A 3-beat packet with in_error = 1: forwarded with out_error = 1 when the macro is not defined; absent from the output with pkt_count = 0 when it is defined.
- rst_n asserted mid-packet with 2 beats written: outputs clear immediately. After release, a new packet passes with no stale beats.
